// File: rtl/pw_pkg.sv
// Shared types and width helpers for the keypad password engine.
package pw_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StProg,
        StLockout
    } pw_state_e;

    // Width of a field holding values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    localparam int unsigned DefKeys   = 4;
    localparam int unsigned DefDigitW = clog2_min1(DefKeys);

endpackage

// File: rtl/key_scan.sv
// Keypad front end: synchronises the raw key lines and emits one event per clean single-key press.
module key_scan
    import pw_pkg::*;
#(
    parameter int unsigned KEYS = 4,
    parameter int unsigned DW   = clog2_min1(KEYS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [KEYS-1:0] key_n_i,
    output logic            evt_o,
    output logic [DW-1:0]   evt_digit_o
);

    logic [KEYS-1:0] sync1_q, sync2_q, prev_q;
    logic [DW-1:0]   idx;
    int unsigned     n_low;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        idx   = '0;
        n_low = 0;
        for (int unsigned i = 0; i < KEYS; i++) begin
            if (!sync2_q[i]) begin
                n_low = n_low + 1;
                idx   = DW'(i);
            end
        end
    end

    // Requiring an all-released previous sample blocks chords and repeats from a held key.
    assign evt_o       = (n_low == 1) && (&prev_q);
    assign evt_digit_o = idx;

endmodule

// File: rtl/password_matcher.sv
// Keypad password engine: entry matching, failed-attempt lockout and in-field reprogramming.
module password_matcher
    import pw_pkg::*;
#(
    parameter int unsigned                         KEYS        = 4,
    parameter int unsigned                         PW_LEN      = 8,
    parameter logic [PW_LEN*clog2_min1(KEYS)-1:0]  DEFAULT_PW  = 16'hE4E4,
    parameter int unsigned                         MAX_FAIL    = 3,
    parameter int unsigned                         LOCK_CYCLES = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [KEYS-1:0]                      key_n_i,
    input  logic                                 clear_i,
    input  logic                                 lock_i,
    input  logic                                 prog_i,
    output logic                                 unlocked_o,
    output logic                                 locked_out_o,
    output logic                                 err_o,
    output logic [clog2_min1(PW_LEN+1)-1:0]      digit_cnt_o,
    output logic [clog2_min1(MAX_FAIL+1)-1:0]    fail_cnt_o
);

    localparam int unsigned DW    = clog2_min1(KEYS);
    localparam int unsigned CntW  = clog2_min1(PW_LEN + 1);
    localparam int unsigned FailW = clog2_min1(MAX_FAIL + 1);
    localparam int unsigned TimW  = clog2_min1(LOCK_CYCLES);
    localparam int unsigned PwW   = PW_LEN * DW;

    logic          evt;
    logic [DW-1:0] evt_digit;

    key_scan #(
        .KEYS (KEYS),
        .DW   (DW)
    ) u_key_scan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_n_i     (key_n_i),
        .evt_o       (evt),
        .evt_digit_o (evt_digit)
    );

    pw_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [FailW-1:0] fail_q;
    logic             mis_q;
    logic             err_q;
    logic [TimW-1:0]  tim_q;
    logic [PwW-1:0]   pw_q;
    logic [PwW-1:0]   shadow_q;

    logic [DW-1:0]    exp_digit;
    logic [PwW-1:0]   shadow_nxt;
    logic             last_digit;
    logic             miss;
    logic [FailW-1:0] fail_inc;

    always_comb begin
        exp_digit  = '0;
        shadow_nxt = shadow_q;
        for (int unsigned i = 0; i < PW_LEN; i++) begin
            if (cnt_q == CntW'(i)) begin
                exp_digit               = pw_q[i*DW +: DW];
                shadow_nxt[i*DW +: DW]  = evt_digit;
            end
        end
    end

    assign last_digit = (cnt_q == CntW'(PW_LEN - 1));
    assign miss       = mis_q | (evt_digit != exp_digit);
    assign fail_inc   = (fail_q == FailW'(MAX_FAIL)) ? fail_q : fail_q + FailW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fail_q   <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            tim_q    <= '0;
            pw_q     <= DEFAULT_PW;
            shadow_q <= DEFAULT_PW;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear_i) begin
                        cnt_q <= '0;
                        mis_q <= 1'b0;
                    end else if (evt) begin
                        if (last_digit) begin
                            cnt_q <= '0;
                            mis_q <= 1'b0;
                            if (!miss) begin
                                state_q <= StOpen;
                                fail_q  <= '0;
                            end else begin
                                err_q  <= 1'b1;
                                fail_q <= fail_inc;
                                if (fail_inc == FailW'(MAX_FAIL)) begin
                                    state_q <= StLockout;
                                    tim_q   <= TimW'(LOCK_CYCLES - 1);
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                            mis_q <= miss;
                        end
                    end
                end
                StOpen: begin
                    if (lock_i) begin
                        state_q <= StIdle;
                    end else if (prog_i) begin
                        state_q <= StProg;
                        cnt_q   <= '0;
                    end
                end
                StProg: begin
                    // Abort keeps the live password; a partial shadow is simply overwritten later.
                    if (clear_i) begin
                        cnt_q   <= '0;
                        state_q <= StOpen;
                    end else if (evt) begin
                        shadow_q <= shadow_nxt;
                        if (last_digit) begin
                            pw_q    <= shadow_nxt;
                            cnt_q   <= '0;
                            state_q <= StOpen;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StLockout: begin
                    if (tim_q == '0) begin
                        state_q <= StIdle;
                        fail_q  <= '0;
                    end else begin
                        tim_q <= tim_q - TimW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign unlocked_o   = (state_q == StOpen) || (state_q == StProg);
    assign locked_out_o = (state_q == StLockout);
    assign err_o        = err_q;
    assign digit_cnt_o  = cnt_q;
    assign fail_cnt_o   = fail_q;

endmodule

// File: tb/tb_password_matcher.sv
// Directed bench for password_matcher with a behavioural model feeding an expected-result queue.
module tb_password_matcher;

    localparam int unsigned KEYS        = 4;
    localparam int unsigned PW_LEN      = 8;
    localparam int unsigned MAX_FAIL    = 3;
    localparam int unsigned LOCK_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       clear, lock, prog;
    logic       unlocked, locked_out, err;
    logic [3:0] digit_cnt;
    logic [1:0] fail_cnt;

    always #5 clk = ~clk;

    password_matcher #(
        .KEYS        (KEYS),
        .PW_LEN      (PW_LEN),
        .DEFAULT_PW  (16'hE4E4),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .key_n_i      (key_n),
        .clear_i      (clear),
        .lock_i       (lock),
        .prog_i       (prog),
        .unlocked_o   (unlocked),
        .locked_out_o (locked_out),
        .err_o        (err),
        .digit_cnt_o  (digit_cnt),
        .fail_cnt_o   (fail_cnt)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       unl;
        logic       lko;
        logic [1:0] fail;
        logic       er;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // Reference model: 0 idle, 1 open, 2 prog, 3 lockout
    int m_pw[8];
    int m_sh[8];
    int m_cnt, m_fail, m_state;
    bit m_mis;

    int lko_cycles = 0;
    always @(negedge clk) if (locked_out === 1'b1) lko_cycles <= lko_cycles + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_pw[i] = i % 4;
        m_cnt = 0; m_fail = 0; m_state = 0; m_mis = 0;
    endtask

    task automatic model_event(input int d, output exp_t e);
        e.er = 1'b0;
        if (m_state == 0) begin
            if (d != m_pw[m_cnt]) m_mis = 1;
            m_cnt++;
            if (m_cnt == PW_LEN) begin
                m_cnt = 0;
                if (!m_mis) begin
                    m_state = 1; m_fail = 0;
                end else begin
                    e.er = 1'b1;
                    m_fail++;
                    if (m_fail == MAX_FAIL) m_state = 3;
                end
                m_mis = 0;
            end
        end else if (m_state == 2) begin
            m_sh[m_cnt] = d;
            m_cnt++;
            if (m_cnt == PW_LEN) begin
                m_pw = m_sh; m_cnt = 0; m_state = 1;
            end
        end
        e.cnt  = 4'(m_cnt);
        e.unl  = (m_state == 1) || (m_state == 2);
        e.lko  = (m_state == 3);
        e.fail = 2'(m_fail);
    endtask

    task automatic sb_check();
        exp_t e;
        e = sb_q.pop_front();
        chk("cnt",  32'(digit_cnt),  32'(e.cnt));
        chk("unl",  32'(unlocked),   32'(e.unl));
        chk("lko",  32'(locked_out), 32'(e.lko));
        chk("fail", 32'(fail_cnt),   32'(e.fail));
        chk("err",  32'(err),        32'(e.er));
    endtask

    task automatic press(input int d);
        exp_t       e;
        int         old_cnt;
        logic [3:0] onehot;
        old_cnt = m_cnt;
        model_event(d, e);
        sb_q.push_back(e);
        onehot = 4'b0001 << d;
        @(negedge clk) key_n = ~onehot;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) chk("pre_cnt", 32'(digit_cnt), 32'(old_cnt));
        @(negedge clk) sb_check();
        @(negedge clk) chk("err_1cyc", 32'(err), 32'd0);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic enter(input logic [15:0] pw);
        for (int i = 0; i < 8; i++) press(int'(pw[2*i +: 2]));
    endtask

    task automatic pulse(input logic c, input logic l, input logic p);
        @(negedge clk) begin clear = c; lock = l; prog = p; end
        @(negedge clk) begin clear = 1'b0; lock = 1'b0; prog = 1'b0; end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; key_n = 4'hF; clear = 1'b0; lock = 1'b0; prog = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("unl", 32'(unlocked), 32'd0);
        chk("lko", 32'(locked_out), 32'd0);
        chk("err", 32'(err), 32'd0);
        chk("cnt", 32'(digit_cnt), 32'd0);
        chk("fail", 32'(fail_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        phase = "open_default";
        enter(16'hE4E4);
        phase = "lock";
        pulse(1'b0, 1'b1, 1'b0); m_state = 0;
        chk("unl", 32'(unlocked), 32'd0);

        phase = "wrong1";
        enter(16'hA4E4);

        phase = "chord";
        press(0); press(1); press(2);
        @(negedge clk) key_n = 4'b1100;
        repeat (10) @(negedge clk);
        chk("chord_cnt", 32'(digit_cnt), 32'd3);
        key_n = 4'b1110;
        repeat (6) @(negedge clk);
        chk("chord_to_single_cnt", 32'(digit_cnt), 32'd3);
        key_n = 4'hF;
        repeat (4) @(negedge clk);

        phase = "hold50";
        model_event(0, e);
        sb_q.push_back(e);
        key_n = 4'b1110;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) chk("pre_cnt", 32'(digit_cnt), 32'd3);
        @(negedge clk) sb_check();
        repeat (50) @(negedge clk);
        chk("held_cnt", 32'(digit_cnt), 32'd4);
        key_n = 4'hF;
        repeat (4) @(negedge clk);

        phase = "clear";
        press(1);
        pulse(1'b1, 1'b0, 1'b0); m_cnt = 0; m_mis = 0;
        chk("cnt", 32'(digit_cnt), 32'd0);
        chk("fail", 32'(fail_cnt), 32'd1);

        phase = "wrong2";
        enter(16'hA4E4);
        phase = "wrong3";
        enter(16'hA4E4);

        phase = "lockout";
        @(negedge clk) key_n = 4'b1110;
        repeat (4) @(negedge clk);
        chk("cnt_in_lockout", 32'(digit_cnt), 32'd0);
        key_n = 4'hF;
        for (int i = 0; i < 40 && locked_out === 1'b1; i++) @(negedge clk);
        chk("lko_exit", 32'(locked_out), 32'd0);
        chk("fail_after", 32'(fail_cnt), 32'd0);
        chk("cnt_after", 32'(digit_cnt), 32'd0);
        @(posedge clk) chk("lko_cycles", 32'(lko_cycles), LOCK_CYCLES);
        m_state = 0; m_fail = 0;
        repeat (2) @(negedge clk);

        phase = "prog";
        enter(16'hE4E4);
        pulse(1'b0, 1'b0, 1'b1); m_state = 2; m_cnt = 0;
        chk("unl", 32'(unlocked), 32'd1);
        enter(16'hFFFF);
        pulse(1'b0, 1'b1, 1'b0); m_state = 0;
        chk("unl_locked", 32'(unlocked), 32'd0);

        phase = "old_pw";
        enter(16'hE4E4);
        phase = "new_pw";
        enter(16'hFFFF);

        phase = "lock_vs_prog";
        pulse(1'b0, 1'b1, 1'b1); m_state = 0;
        chk("unl", 32'(unlocked), 32'd0);
        enter(16'hFFFF);

        phase = "reset_in_prog";
        pulse(1'b0, 1'b0, 1'b1); m_state = 2; m_cnt = 0;
        press(2); press(2); press(2);
        @(negedge clk) #2 rst_n = 1'b0;
        #1;
        chk("unl", 32'(unlocked), 32'd0);
        chk("cnt", 32'(digit_cnt), 32'd0);
        chk("lko", 32'(locked_out), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        phase = "default_restored";
        enter(16'hE4E4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
